dmem_access_sequencer: RTL and testbench
========================================

Name: dmem_access_sequencer

Overview:
Sequences the memory stage of the 5-stage MIPS pipeline against a variable-latency data memory using a req/ack handshake. It takes the memory-stage control and data fields from the EX/MEM pipeline register. While an access is in flight it stalls the pipeline, and it returns load data to the MEM/WB path. It also detects misaligned word accesses and memory timeouts, and counts stall cycles.

Parameters:
TIMEOUT, 16, max WAIT cycles without DMAck before the access is aborted (range 2..255)
CNT_W, 32, width of the saturating stall-cycle counter

Ports:
CLK  in  1  pipeline clock; all state changes on rising edge
RSTN  in  1  asynchronous active-low reset
MtoRFSelM  in  1  current MEM-stage instruction is a load
DMWEM  in  1  current MEM-stage instruction is a store
ALUOutM  in  32  byte address of the access
DMdinM  in  32  store data
DMAck  in  1  memory completion, single-cycle pulse
DMRData  in  32  load data, valid with DMAck
DMReq  out  1  memory request, held until ack or abort
DMWE  out  1  memory write enable, valid with DMReq
DMAddr  out  32  registered address to memory
DMWData  out  32  registered store data to memory
StallM  out  1  freeze PC and the IF/ID, ID/EX and EX/MEM registers
ReadDataM  out  32  load result toward MEM/WB
ReadValidM  out  1  ReadDataM valid, 1-cycle pulse
AlignErr  out  1  misaligned access, 1-cycle pulse
BusErr  out  1  timeout abort, 1-cycle pulse
StallCount  out  CNT_W  cycles with StallM=1, saturating

Behaviour:
- One clock, CLK. Reset RSTN is asynchronous, active-low. Reset forces state IDLE and clears every registered output: DMReq, DMWE, DMAddr, DMWData, ReadDataM, ReadValidM, AlignErr, BusErr, StallCount, and the timeout counter. StallM is 0 while RSTN=0.
- access = MtoRFSelM | DMWEM. If both are set, the access is a store (DMWEM has priority).
- State IDLE:
  - No access: stay in IDLE, StallM=0.
  - Access with ALUOutM[1:0]!=0: go to DONE. AlignErr=1 and ReadDataM=0 in DONE. No request is issued.
  - Aligned access: go to WAIT. Latch DMAddr=ALUOutM, DMWData=DMdinM, DMWE=store, DMReq=1, timeout counter=0.
  - StallM is combinational and equals 1 in IDLE whenever access=1.
- State WAIT:
  - StallM=1 and DMReq=1. DMAddr, DMWData and DMWE are stable.
  - The counter increments each cycle.
  - DMAck=1: go to DONE and drop DMReq. For a load, capture ReadDataM=DMRData and set ReadValidM=1.
  - Counter reaches TIMEOUT-1 without an ack: go to DONE, drop DMReq, BusErr=1, ReadDataM=0, ReadValidM=0.
  - If the ack and the timeout fall on the same cycle, the ack wins.
- State DONE:
  - StallM=0, so the pipeline registers advance at the end of this cycle. The EX/MEM contents are unchanged during DONE and must not be re-issued.
  - The one-cycle pulses (ReadValidM, AlignErr, BusErr) are high only during DONE.
  - Always returns to IDLE. ReadDataM holds its value until the next load completes.
- Minimum aligned-access latency: 3 cycles (IDLE, WAIT with ack on its first cycle, DONE). Stall cycles = 1 + WAIT cycles.
- A back-to-back access is evaluated in the IDLE cycle that follows DONE.
- DMAck in IDLE or DONE is ignored.
- StallCount increments on every cycle with StallM=1 and saturates at all-ones.
- Reset asserted mid-WAIT: DMReq drops immediately and asynchronously. Memory must tolerate an abandoned request.

Test Plan:
- Reset mid-WAIT: reset asserted with DMReq=1 -> DMReq, StallM and StallCount all 0 immediately, before the next clock edge.
- Load: addr 0x0000_0010, DMAck on 2nd WAIT cycle with DMRData=0xCAFE_F00D -> StallM high 3 cycles; DONE shows ReadDataM=0xCAFE_F00D, ReadValidM=1; StallCount=3.
- Store: addr 0x0000_0020, data 0x1234_5678, immediate ack -> DMReq=1, DMWE=1, DMAddr/DMWData as given for exactly 1 cycle; ReadValidM stays 0; StallCount=2.
- Misaligned load at 0x0000_0013 -> DMReq never asserts; AlignErr pulses in DONE; StallM high 1 cycle.
- Timeout with TIMEOUT=4, no ack -> DMReq high 4 cycles, then BusErr pulses, ReadDataM=0. Repeat with ack on the 4th WAIT cycle -> ack wins, BusErr=0.
- Load and store both asserted, then back-to-back loads -> the first is treated as a store (DMWE=1); the second access's DMReq rises 2 cycles after the first's DONE (its IDLE cycle, then WAIT). StallCount saturation checked with CNT_W=3 -> holds at 7.

Source files
------------

// File: rtl/dmem_access_sequencer.sv
// Memory-stage sequencer: issues one req/ack data-memory access per load/store and freezes the pipeline meanwhile.
// Latency: aligned access takes IDLE + WAIT(1..TIMEOUT) + DONE cycles; a misaligned access takes IDLE + DONE.
// Backpressure: StallM holds the upstream pipeline while the access is pending; the memory side holds off via DMAck.
module dmem_access_sequencer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             MtoRFSelM,
   input  logic             DMWEM,
   input  logic [31:0]      ALUOutM,
   input  logic [31:0]      DMdinM,
   input  logic             DMAck,
   input  logic [31:0]      DMRData,
   output logic             DMReq,
   output logic             DMWE,
   output logic [31:0]      DMAddr,
   output logic [31:0]      DMWData,
   output logic             StallM,
   output logic [31:0]      ReadDataM,
   output logic             ReadValidM,
   output logic             AlignErr,
   output logic             BusErr,
   output logic [CNT_W-1:0] StallCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Last WAIT-cycle count value before the access is abandoned.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic       access;
   logic       misaligned;
   logic       timeout_hit;
   logic       stall_raw;
   logic       issue;
   logic       reject;
   logic       ack_take;
   logic       abort;

   // A store wins when both load and store are flagged, so access only needs the OR.
   assign access      = MtoRFSelM | DMWEM;
   assign misaligned  = |ALUOutM[1:0];
   assign timeout_hit = (wait_cnt == TO_LAST);

   // Event decode shared by the state machine and the datapath registers.
   assign issue    = (state == IDLE) && access && !misaligned;
   assign reject   = (state == IDLE) && access && misaligned;
   assign ack_take = (state == WAIT) && DMAck;
   assign abort    = (state == WAIT) && !DMAck && timeout_hit;

   // State register.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and combinational stall; ack beats timeout in the same cycle.
   always_comb begin
      state_nxt = state;
      stall_raw = 1'b0;
      case (state)
         IDLE: begin
            stall_raw = access;
            if (access) begin
               state_nxt = misaligned ? DONE : WAIT;
            end
         end
         WAIT: begin
            stall_raw = 1'b1;
            if (DMAck || timeout_hit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Stall is forced low during reset even though the inputs may still show an access.
   assign StallM = RSTN & stall_raw;

   // Request side: latch address/data/direction on issue, hold through WAIT, drop on ack or abort.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         DMReq    <= 1'b0;
         DMWE     <= 1'b0;
         DMAddr   <= 32'd0;
         DMWData  <= 32'd0;
         wait_cnt <= 8'd0;
      end else if (issue) begin
         DMReq    <= 1'b1;
         DMWE     <= DMWEM;
         DMAddr   <= ALUOutM;
         DMWData  <= DMdinM;
         wait_cnt <= 8'd0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 8'd1;
         if (ack_take || abort) begin
            DMReq <= 1'b0;
            DMWE  <= 1'b0;
         end
      end
   end

   // Response side: single-cycle status pulses land in DONE; load data persists until the next load.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         ReadDataM  <= 32'd0;
         ReadValidM <= 1'b0;
         AlignErr   <= 1'b0;
         BusErr     <= 1'b0;
      end else begin
         ReadValidM <= 1'b0;
         AlignErr   <= 1'b0;
         BusErr     <= 1'b0;
         if (reject) begin
            AlignErr  <= 1'b1;
            ReadDataM <= 32'd0;
         end else if (ack_take) begin
            // DMWE still holds the latched direction of the access being acked.
            if (!DMWE) begin
               ReadDataM  <= DMRData;
               ReadValidM <= 1'b1;
            end
         end else if (abort) begin
            BusErr    <= 1'b1;
            ReadDataM <= 32'd0;
         end
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         StallCount <= '0;
      end else if (stall_raw && (StallCount != {CNT_W{1'b1}})) begin
         StallCount <= StallCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Bench for dmem_access_sequencer: transaction-level model drives directed and random loads/stores.
// Latency: each access is checked cycle by cycle from its IDLE cycle to its DONE cycle.
// Backpressure: memory ack delay is chosen per access, including never (timeout).
module tb_dmem_access_sequencer;

   localparam int TO = 4;

   logic        CLK;
   logic        RSTN;
   logic        MtoRFSelM;
   logic        DMWEM;
   logic [31:0] ALUOutM;
   logic [31:0] DMdinM;
   logic        DMAck;
   logic [31:0] DMRData;

   logic        DMReq, DMWE, StallM, ReadValidM, AlignErr, BusErr;
   logic [31:0] DMAddr, DMWData, ReadDataM;
   logic [31:0] StallCount;

   logic        s_DMReq, s_DMWE, s_StallM, s_ReadValidM, s_AlignErr, s_BusErr;
   logic [31:0] s_DMAddr, s_DMWData, s_ReadDataM;
   logic [2:0]  s_StallCount;

   int unsigned tests;
   int unsigned fails;
   int unsigned stall_total;
   logic [31:0] rd_model;

   dmem_access_sequencer #(.TIMEOUT(TO), .CNT_W(32)) u_dut (
      .CLK(CLK), .RSTN(RSTN), .MtoRFSelM(MtoRFSelM), .DMWEM(DMWEM),
      .ALUOutM(ALUOutM), .DMdinM(DMdinM), .DMAck(DMAck), .DMRData(DMRData),
      .DMReq(DMReq), .DMWE(DMWE), .DMAddr(DMAddr), .DMWData(DMWData),
      .StallM(StallM), .ReadDataM(ReadDataM), .ReadValidM(ReadValidM),
      .AlignErr(AlignErr), .BusErr(BusErr), .StallCount(StallCount)
   );

   dmem_access_sequencer #(.TIMEOUT(TO), .CNT_W(3)) u_sat (
      .CLK(CLK), .RSTN(RSTN), .MtoRFSelM(MtoRFSelM), .DMWEM(DMWEM),
      .ALUOutM(ALUOutM), .DMdinM(DMdinM), .DMAck(DMAck), .DMRData(DMRData),
      .DMReq(s_DMReq), .DMWE(s_DMWE), .DMAddr(s_DMAddr), .DMWData(s_DMWData),
      .StallM(s_StallM), .ReadDataM(s_ReadDataM), .ReadValidM(s_ReadValidM),
      .AlignErr(s_AlignErr), .BusErr(s_BusErr), .StallCount(s_StallCount)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Compare the per-cycle observable outputs against the model's expectations.
   task automatic check_cycle(input string tag, input bit stall, input bit req,
                              input bit rv, input bit ae, input bit be);
      int unsigned sat;
      sat = (stall_total > 7) ? 7 : stall_total;
      chk({tag, ".StallM"}, {31'd0, StallM}, {31'd0, stall});
      chk({tag, ".DMReq"}, {31'd0, DMReq}, {31'd0, req});
      chk({tag, ".ReadValidM"}, {31'd0, ReadValidM}, {31'd0, rv});
      chk({tag, ".AlignErr"}, {31'd0, AlignErr}, {31'd0, ae});
      chk({tag, ".BusErr"}, {31'd0, BusErr}, {31'd0, be});
      chk({tag, ".ReadDataM"}, ReadDataM, rd_model);
      chk({tag, ".StallCount"}, StallCount, stall_total);
      chk({tag, ".StallCount3"}, {29'd0, s_StallCount}, sat);
      if (stall) stall_total++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         MtoRFSelM = 1'b0;
         DMWEM     = 1'b0;
         ALUOutM   = $urandom;
         DMdinM    = $urandom;
         DMAck     = 1'($urandom % 2);
         DMRData   = $urandom;
         #1;
         check_cycle("idle", 0, 0, 0, 0, 0);
      end
   endtask

   // One access: ack_at is the WAIT cycle (1-based) carrying DMAck, 0 or >TO means never.
   task automatic do_access(input string tag, input bit ld, input bit st,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rd);
      bit store;
      bit load;
      bit acked;
      int n_wait;
      store = st;
      load  = ld && !st;
      @(negedge CLK);
      MtoRFSelM = ld;
      DMWEM     = st;
      ALUOutM   = addr;
      DMdinM    = wd;
      DMAck     = 1'($urandom % 2);
      DMRData   = $urandom;
      #1;
      check_cycle({tag, ".idle"}, 1, 0, 0, 0, 0);
      if (addr[1:0] != 2'b00) begin
         @(negedge CLK);
         DMAck = 1'($urandom % 2);
         #1;
         rd_model = 32'd0;
         check_cycle({tag, ".align_done"}, 0, 0, 0, 1, 0);
      end else begin
         acked  = (ack_at >= 1) && (ack_at <= TO);
         n_wait = acked ? ack_at : TO;
         for (int k = 1; k <= n_wait; k++) begin
            @(negedge CLK);
            DMAck   = (k == ack_at);
            DMRData = (k == ack_at) ? rd : $urandom;
            #1;
            check_cycle({tag, ".wait"}, 1, 1, 0, 0, 0);
            chk({tag, ".DMWE"}, {31'd0, DMWE}, {31'd0, store});
            chk({tag, ".DMAddr"}, DMAddr, addr);
            chk({tag, ".DMWData"}, DMWData, wd);
         end
         @(negedge CLK);
         DMAck   = 1'($urandom % 2);
         DMRData = $urandom;
         #1;
         if (acked && load) rd_model = rd;
         else if (!acked) rd_model = 32'd0;
         check_cycle({tag, ".done"}, 0, 0, acked && load, 0, !acked);
      end
   endtask

   initial begin
      logic [31:0] a;
      bit ld, st;
      tests = 0;
      fails = 0;
      stall_total = 0;
      rd_model = 32'd0;
      RSTN = 1'b0;
      MtoRFSelM = 1'b0;
      DMWEM = 1'b0;
      ALUOutM = 32'd0;
      DMdinM = 32'd0;
      DMAck = 1'b0;
      DMRData = 32'd0;

      // Reset state
      #12;
      check_cycle("reset", 0, 0, 0, 0, 0);
      chk("reset.DMAddr", DMAddr, 32'd0);
      chk("reset.DMWData", DMWData, 32'd0);
      chk("reset.DMWE", {31'd0, DMWE}, 32'd0);
      @(negedge CLK);
      RSTN = 1'b1;

      // Reset asserted mid-WAIT with the access still presented
      @(negedge CLK);
      MtoRFSelM = 1'b1;
      ALUOutM   = 32'h0000_0100;
      DMAck     = 1'b0;
      #1;
      check_cycle("rstw.idle", 1, 0, 0, 0, 0);
      @(negedge CLK);
      #1;
      check_cycle("rstw.wait", 1, 1, 0, 0, 0);
      #2;
      RSTN = 1'b0;
      #1;
      chk("rstw.DMReq", {31'd0, DMReq}, 32'd0);
      chk("rstw.StallM", {31'd0, StallM}, 32'd0);
      chk("rstw.StallCount", StallCount, 32'd0);
      chk("rstw.StallCount3", {29'd0, s_StallCount}, 32'd0);
      MtoRFSelM = 1'b0;
      @(negedge CLK);
      RSTN = 1'b1;
      stall_total = 0;
      rd_model = 32'd0;

      // Directed cases
      do_access("load", 1, 0, 32'h0000_0010, 32'h0, 2, 32'hCAFE_F00D);
      idle_cycles(1);
      chk("load.count", StallCount, 32'd3);
      do_access("store", 0, 1, 32'h0000_0020, 32'h1234_5678, 1, 32'hDEAD_BEEF);
      idle_cycles(1);
      chk("store.count", StallCount, 32'd5);
      chk("store.keep_rd", ReadDataM, 32'hCAFE_F00D);
      do_access("misal", 1, 0, 32'h0000_0013, 32'h0, 1, 32'h0);
      idle_cycles(1);
      do_access("tmo", 1, 0, 32'h0000_0030, 32'h0, 0, 32'h0);
      do_access("ack4", 1, 0, 32'h0000_0034, 32'h0, 4, 32'h5A5A_A5A5);
      do_access("both", 1, 1, 32'h0000_0040, 32'h0BAD_F00D, 1, 32'h1111_1111);
      do_access("b2b1", 1, 0, 32'h0000_0044, 32'h0, 1, 32'h2222_2222);
      do_access("b2b2", 1, 0, 32'h0000_0048, 32'h0, 3, 32'h3333_3333);
      idle_cycles(2);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         ld = 1'($urandom % 2);
         st = 1'($urandom % 2);
         if (!ld && !st) ld = 1'b1;
         a = $urandom;
         if (($urandom % 4) != 0) a[1:0] = 2'b00;
         do_access("rand", ld, st, a, $urandom, int'($urandom_range(0, 5)), $urandom);
         idle_cycles(int'($urandom_range(0, 2)));
      end
      idle_cycles(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
